regfile_wb_arbiter: RTL

- Shares the single register-file write port between two writeback sources: ALU results and load/memory results.
- Each source uses a valid/ready handshake. The block round-robins between them and drives registered we/w/data_in toward the register file.
- A scoreboard holds one busy bit per architectural register. Issue logic sets the bit when an instruction issues and this block clears it on commit, so the decode stage can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback, scoreboard and register-file signal bundle
//
// Groups the ALU and memory writeback handshakes, the issue/flush/check
// scoreboard signals and the registered register-file write port.
// Modport slave : the arbiter (consumes valids, produces readies and rf_*).
// Modport master: the writeback sources, issue logic and register file.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [AW-1:0]   rf_w;
    logic [XLEN-1:0] rf_data;
    logic [NREG-1:0] busy_vec;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd, flush, chk_rs1, chk_rs2,
        output rs1_busy, rs2_busy,
        output rf_we, rf_w, rf_data, busy_vec
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd, flush, chk_rs1, chk_rs2,
        input  rs1_busy, rs2_busy,
        input  rf_we, rf_w, rf_data, busy_vec
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with register scoreboard
//
// Ports:
//   clk   - system clock, all state updates on posedge
//   reset - synchronous, active-high reset
//   bus   - regfile_wb_arbiter_if.slave: ALU/MEM valid-ready writebacks,
//           issue/flush scoreboard control, rs1/rs2 busy lookup,
//           registered rf_we/rf_w/rf_data and debug busy_vec
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_wb_arbiter_if.slave     bus
);
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_grant_e;

    last_grant_e     last_grant_q;
    logic            rf_we_q;
    logic [AW-1:0]   rf_w_q;
    logic [XLEN-1:0] rf_data_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            alu_win;
    logic            mem_win;
    logic            accept;
    logic [AW-1:0]   acc_rd;
    logic [XLEN-1:0] acc_data;

    // Under contention the source that did not win last time gets the port.
    always_comb begin
        alu_win  = bus.alu_valid && (!bus.mem_valid || last_grant_q == LAST_MEM);
        mem_win  = bus.mem_valid && !alu_win;
        accept   = alu_win || mem_win;
        acc_rd   = alu_win ? bus.alu_rd   : bus.mem_rd;
        acc_data = alu_win ? bus.alu_data : bus.mem_data;
    end

    // Clear on commit, then flush, then set on issue: a newer writer to the
    // same register must stay visible, and issue survives a flush.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && rf_w_q != '0) begin
            busy_d[rf_w_q] = 1'b0;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= LAST_MEM;
            rf_we_q      <= 1'b0;
            rf_w_q       <= '0;
            rf_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            busy_q <= busy_d;
            if (bus.alu_valid && bus.mem_valid) begin
                last_grant_q <= alu_win ? LAST_ALU : LAST_MEM;
            end
            // x0 writes complete the handshake but never reach the file;
            // rf_w/rf_data keep their old contents in that case.
            rf_we_q <= accept && acc_rd != '0;
            if (accept && acc_rd != '0) begin
                rf_w_q    <= acc_rd;
                rf_data_q <= acc_data;
            end
        end
    end

    assign bus.alu_ready = alu_win;
    assign bus.mem_ready = mem_win;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_w      = rf_w_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.busy_vec  = busy_q;
    assign bus.rs1_busy  = busy_q[bus.chk_rs1];
    assign bus.rs2_busy  = busy_q[bus.chk_rs2];
endmodule
